// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
// The top register is the hardwired zero register and is never written.
package regfile_pkg;
   localparam int MAdr     = 5;
   localparam int Mdata    = 32;
   localparam int Mreg     = 2 ** MAdr;
   localparam int ZERO_REG = Mreg - 1;

   typedef enum logic {INIT, ARB} wb_state_t;
   typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback requester and register-file write bundle.
// The master side is the writeback stage; the slave side is the arbiter.
interface regfile_wr_arbiter_if;
   import regfile_pkg::*;

   logic             a_valid;
   logic [MAdr-1:0]  a_adr;
   logic [Mdata-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [MAdr-1:0]  b_adr;
   logic [Mdata-1:0] b_data;
   logic             b_ready;
   logic             wrtEnable;
   logic [MAdr-1:0]  wrtAdr;
   logic [Mdata-1:0] wrtData;
   logic             init_done;

   modport master (
      output a_valid, a_adr, a_data, b_valid, b_adr, b_data,
      input  a_ready, b_ready, wrtEnable, wrtAdr, wrtData, init_done
   );

   modport slave (
      input  a_valid, a_adr, a_data, b_valid, b_adr, b_data,
      output a_ready, b_ready, wrtEnable, wrtAdr, wrtData, init_done
   );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter_2
   import regfile_pkg::*;
(
   input  logic [1:0] i_valid,
   input  req_id_t    i_last_grant,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = (i_last_grant == REQ_B) ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: clears R0..R30 after reset, then
// shares the port between the ALU (A) and load (B) writeback requesters.
module regfile_wr_arbiter
   import regfile_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   regfile_wr_arbiter_if.slave  bus
);

   localparam logic [MAdr-1:0] LastClr = MAdr'(Mreg - 2);
   localparam logic [MAdr-1:0] ZeroAdr = MAdr'(ZERO_REG);

   wb_state_t        r_state;
   wb_state_t        w_state_nxt;
   logic [MAdr-1:0]  r_clr_cnt;
   req_id_t          r_last_grant;
   logic             r_wrt_en;
   logic [MAdr-1:0]  r_wrt_adr;
   logic [Mdata-1:0] r_wrt_data;
   logic             r_init_done;

   logic [1:0]       w_grant;
   logic             w_a_ready;
   logic             w_b_ready;
   logic             w_xfer;
   logic             w_do_write;
   logic [MAdr-1:0]  w_xfer_adr;
   logic [Mdata-1:0] w_xfer_data;

   rr_arbiter_2 u_rr (
      .i_valid      ({bus.b_valid, bus.a_valid}),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == INIT && r_clr_cnt == LastClr) begin
         w_state_nxt = ARB;
      end
   end

   // Requesters are only served once the clear sequence has handed over.
   always_comb begin
      w_a_ready = 1'b0;
      w_b_ready = 1'b0;
      if (r_state == ARB) begin
         w_a_ready = w_grant[0];
         w_b_ready = w_grant[1];
      end
   end

   always_comb begin
      w_xfer      = w_a_ready | w_b_ready;
      w_xfer_adr  = w_b_ready ? bus.b_adr  : bus.a_adr;
      w_xfer_data = w_b_ready ? bus.b_data : bus.a_data;
      w_do_write  = w_xfer && (w_xfer_adr != ZeroAdr);
   end

   // Writes aimed at the zero register are accepted but silently dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_cnt    <= '0;
         r_last_grant <= REQ_B;
         r_wrt_en     <= 1'b0;
         r_wrt_adr    <= '0;
         r_wrt_data   <= '0;
         r_init_done  <= 1'b0;
      end else if (r_state == INIT) begin
         r_wrt_en   <= 1'b1;
         r_wrt_adr  <= r_clr_cnt;
         r_wrt_data <= '0;
         r_clr_cnt  <= r_clr_cnt + 1'b1;
         if (r_clr_cnt == LastClr) begin
            r_init_done <= 1'b1;
         end
      end else begin
         r_wrt_en <= w_do_write;
         if (w_do_write) begin
            r_wrt_adr  <= w_xfer_adr;
            r_wrt_data <= w_xfer_data;
         end
         if (w_xfer) begin
            r_last_grant <= w_b_ready ? REQ_B : REQ_A;
         end
      end
   end

   assign bus.a_ready   = w_a_ready;
   assign bus.b_ready   = w_b_ready;
   assign bus.wrtEnable = r_wrt_en;
   assign bus.wrtAdr    = r_wrt_adr;
   assign bus.wrtData   = r_wrt_data;
   assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural register file
// fed from the write port.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic rf_preset;
   logic [31:0] rf [32];
   int n_checks = 0;
   int n_errors = 0;

   regfile_wr_arbiter_if bus ();

   regfile_wr_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Register file model; R31 starts at zero and must never be written.
   always @(posedge clk) begin
      if (rf_preset) begin
         for (int i = 0; i < 32; i++) rf[i] <= (i == 31) ? 32'h0 : 32'hFFFF_FFFF;
      end else if (bus.wrtEnable) begin
         rf[bus.wrtAdr] <= bus.wrtData;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int av, input int aa, input int ad,
                        input int bv, input int ba, input int bd);
      bus.a_valid = (av != 0);
      bus.a_adr   = 5'(aa);
      bus.a_data  = 32'(ad);
      bus.b_valid = (bv != 0);
      bus.b_adr   = 5'(ba);
      bus.b_data  = 32'(bd);
   endtask

   // Expects the clear sequence to start on the next edge; valids are
   // left as the caller set them until the last INIT cycle.
   task automatic check_clear_seq(input string tag);
      for (int i = 0; i < 31; i++) begin
         step;
         check({tag, "_wen"},  32'(bus.wrtEnable), 32'd1);
         check({tag, "_adr"},  32'(bus.wrtAdr), i);
         check({tag, "_data"}, bus.wrtData, 32'h0);
         if (i < 30) begin
            check({tag, "_init_low"}, 32'(bus.init_done), 32'd0);
            check({tag, "_rdy_low"},  32'({bus.a_ready, bus.b_ready}), 32'd0);
         end
         if (i == 29) drive(0, 0, 0, 0, 0, 0);
      end
      step;
      check({tag, "_wen_off"}, 32'(bus.wrtEnable), 32'd0);
      check({tag, "_init_hi"}, 32'(bus.init_done), 32'd1);
   endtask

   initial begin
      int bad;
      reset     = 1'b1;
      rf_preset = 1'b1;
      drive(1, 5, 32'hAAAA, 1, 6, 32'hBBBB);
      step;
      step;
      check("rst_wen",   32'(bus.wrtEnable), 32'd0);
      check("rst_adr",   32'(bus.wrtAdr), 32'd0);
      check("rst_data",  bus.wrtData, 32'h0);
      check("rst_init",  32'(bus.init_done), 32'd0);
      check("rst_ardy",  32'(bus.a_ready), 32'd0);
      check("rst_brdy",  32'(bus.b_ready), 32'd0);
      rf_preset = 1'b0;
      reset     = 1'b0;
      check_clear_seq("clr");

      bad = 0;
      for (int i = 0; i < 31; i++) if (rf[i] !== 32'h0) bad++;
      check("rf_cleared", bad, 0);
      check("rf_r31_clr", rf[31], 32'h0);

      // A alone
      drive(1, 3, 32'hDEADBEEF, 0, 0, 0);
      #1;
      check("a_only_ardy", 32'(bus.a_ready), 32'd1);
      check("a_only_brdy", 32'(bus.b_ready), 32'd0);
      step;
      drive(0, 0, 0, 0, 0, 0);
      check("a_only_wen",  32'(bus.wrtEnable), 32'd1);
      check("a_only_adr",  32'(bus.wrtAdr), 32'd3);
      check("a_only_data", bus.wrtData, 32'hDEADBEEF);
      step;
      check("a_only_idle_wen", 32'(bus.wrtEnable), 32'd0);
      check("a_only_hold_adr", 32'(bus.wrtAdr), 32'd3);
      check("a_only_rf3",      rf[3], 32'hDEADBEEF);

      // B to the zero register
      drive(0, 0, 0, 1, 31, 32'h1234);
      #1;
      check("b31_brdy", 32'(bus.b_ready), 32'd1);
      check("b31_ardy", 32'(bus.a_ready), 32'd0);
      step;
      drive(0, 0, 0, 0, 0, 0);
      check("b31_wen", 32'(bus.wrtEnable), 32'd0);
      step;
      check("b31_rf31", rf[31], 32'h0);

      // Both valid: last grant is B, so A,B,A,B
      drive(1, 1, 32'h11, 1, 2, 32'h22);
      for (int k = 0; k < 4; k++) begin
         #1;
         check("both_ardy", 32'(bus.a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         check("both_brdy", 32'(bus.b_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
         step;
         check("both_wen",  32'(bus.wrtEnable), 32'd1);
         check("both_adr",  32'(bus.wrtAdr), (k % 2 == 0) ? 32'd1 : 32'd2);
         check("both_data", bus.wrtData, (k % 2 == 0) ? 32'h11 : 32'h22);
      end
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("idle_rdy", 32'({bus.a_ready, bus.b_ready}), 32'd0);
      step;
      check("idle_wen", 32'(bus.wrtEnable), 32'd0);

      // B alone three times, then a tie must go to A
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, 7, 32'h70 + k);
         #1;
         check("bonly_brdy", 32'(bus.b_ready), 32'd1);
         step;
         check("bonly_adr",  32'(bus.wrtAdr), 32'd7);
         check("bonly_data", bus.wrtData, 32'h70 + k);
      end
      drive(1, 8, 32'h88, 1, 9, 32'h99);
      #1;
      check("tie_ardy", 32'(bus.a_ready), 32'd1);
      check("tie_brdy", 32'(bus.b_ready), 32'd0);
      step;
      check("tie_adr",  32'(bus.wrtAdr), 32'd8);
      check("rf7",      rf[7], 32'h72);

      // Reset in ARB with a pending request: the write is dropped
      drive(1, 4, 32'h44, 0, 0, 0);
      reset = 1'b1;
      step;
      check("arb_rst_wen",  32'(bus.wrtEnable), 32'd0);
      check("arb_rst_adr",  32'(bus.wrtAdr), 32'd0);
      check("arb_rst_init", 32'(bus.init_done), 32'd0);
      check("arb_rst_ardy", 32'(bus.a_ready), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step;
         check("part_clr_adr", 32'(bus.wrtAdr), i);
      end

      // Reset with clr_cnt at 10: clear restarts from address 0
      reset = 1'b1;
      step;
      check("mid_rst_wen",  32'(bus.wrtEnable), 32'd0);
      check("mid_rst_adr",  32'(bus.wrtAdr), 32'd0);
      check("mid_rst_data", bus.wrtData, 32'h0);
      check("mid_rst_init", 32'(bus.init_done), 32'd0);
      reset = 1'b0;
      check_clear_seq("reclr");
      check("rf4_untouched", rf[4], 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
